// File: rtl/divide_if.sv
// Operand/result handshake bundle for the divide block.
// The master drives operands and out_ready; the slave is the divider.
interface divide_if #(
    parameter int WIDTH = 16
);
    logic                   in_valid;
    logic                   in_ready;
    logic [2*WIDTH-1:0]     dividend;
    logic [WIDTH-1:0]       divisor;
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH-1:0]       quotient;
    logic [WIDTH-1:0]       remainder;
    logic                   err_dbz;
    logic                   err_ovf;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, err_dbz, err_ovf
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, err_dbz, err_ovf
    );
endinterface

// File: rtl/divide.sv
// Sequential restoring divider: 2*WIDTH / WIDTH -> WIDTH quotient, one bit per cycle.
// Define DIVIDE_REMAINDER_EN to drive the remainder port; otherwise it is tied to 0.
//
// state | meaning
// IDLE  | in_ready=1, waiting for operands
// BUSY  | WIDTH restoring steps, MSB first
// DONE  | result (or error) presented until out_ready
module divide #(
    parameter int WIDTH = 16
) (
    input  logic      clk,
    input  logic      rst,
    divide_if.slave   bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state;
    logic [WIDTH-1:0]   dvs;
    logic [WIDTH-1:0]   dvd_lo;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH:0]     prem;
    logic [CW-1:0]      cnt;

    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic [WIDTH:0]     prem_nxt;
    logic               qbit;
    logic               last_step;

    // Partial remainder stays below divisor, so its top bit is free for the shift.
    always_comb begin
        shifted   = {prem[WIDTH-1:0], dvd_lo[WIDTH-1]};
        diff      = shifted - {1'b0, dvs};
        qbit      = (shifted >= {1'b0, dvs});
        prem_nxt  = qbit ? diff : shifted;
        last_step = (state == BUSY) && (cnt == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            bus.in_ready <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.quotient <= '0;
            bus.err_dbz  <= 1'b0;
            bus.err_ovf  <= 1'b0;
            dvs          <= '0;
            dvd_lo       <= '0;
            quo          <= '0;
            prem         <= '0;
            cnt          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        dvs          <= bus.divisor;
                        dvd_lo       <= bus.dividend[WIDTH-1:0];
                        prem         <= {1'b0, bus.dividend[2*WIDTH-1:WIDTH]};
                        quo          <= '0;
                        cnt          <= CW'(WIDTH - 1);
                        bus.in_ready <= 1'b0;
                        if (bus.divisor == '0) begin
                            state         <= DONE;
                            bus.out_valid <= 1'b1;
                            bus.quotient  <= '1;
                            bus.err_dbz   <= 1'b1;
                        end else if (bus.dividend[2*WIDTH-1:WIDTH] >= bus.divisor) begin
                            state         <= DONE;
                            bus.out_valid <= 1'b1;
                            bus.quotient  <= '1;
                            bus.err_ovf   <= 1'b1;
                        end else begin
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    prem   <= prem_nxt;
                    dvd_lo <= {dvd_lo[WIDTH-2:0], 1'b0};
                    quo    <= {quo[WIDTH-2:0], qbit};
                    cnt    <= cnt - 1'b1;
                    if (cnt == '0) begin
                        state         <= DONE;
                        bus.out_valid <= 1'b1;
                        bus.quotient  <= {quo[WIDTH-2:0], qbit};
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state         <= IDLE;
                        bus.in_ready  <= 1'b1;
                        bus.out_valid <= 1'b0;
                        bus.quotient  <= '0;
                        bus.err_dbz   <= 1'b0;
                        bus.err_ovf   <= 1'b0;
                    end
                end
                default: begin
                    state         <= IDLE;
                    bus.in_ready  <= 1'b1;
                    bus.out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef DIVIDE_REMAINDER_EN
    logic [WIDTH-1:0] rem_q;

    // Error results leave this at 0; it is only loaded on the final step.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q <= '0;
        end else if (last_step) begin
            rem_q <= prem_nxt[WIDTH-1:0];
        end else if (state == DONE && bus.out_ready) begin
            rem_q <= '0;
        end
    end

    assign bus.remainder = rem_q;
`else
    assign bus.remainder = '0;
`endif

endmodule

// File: doc/divide.md
DIVIDE -- requirements
Module: divide

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the divisor/quotient/remainder width; a power of two, 4 to 64.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, the reset; synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1, operands present.
REQ-005 SHALL have port in_ready, output, 1, block can accept operands.
REQ-006 SHALL have port dividend, input, 2*WIDTH, unsigned dividend.
REQ-007 SHALL have port divisor, input, WIDTH, unsigned divisor.
REQ-008 SHALL have port out_valid, output, 1, result present.
REQ-009 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-010 SHALL have port quotient, output, WIDTH, unsigned quotient.
REQ-011 SHALL have port remainder, output, WIDTH, unsigned remainder.
REQ-012 SHALL have port err_dbz, output, 1, divisor was zero.
REQ-013 SHALL have port err_ovf, output, 1, quotient does not fit in WIDTH bits.

Function
REQ-014 SHALL implement states IDLE, BUSY and DONE.
REQ-015 SHALL drive in_ready=1 only in IDLE; operands are accepted on a cycle with in_valid=1 and in_ready=1.
REQ-016 SHALL register dividend and divisor on accept; later changes to the inputs have no effect on that operation.
REQ-017 SHALL on accept with divisor==0 go IDLE->DONE with err_dbz=1, err_ovf=0, quotient=all ones, remainder=0.
REQ-018 SHALL on accept with divisor!=0 and dividend[2*WIDTH-1:WIDTH] >= divisor go IDLE->DONE with err_ovf=1, err_dbz=0, quotient=all ones, remainder=0.
REQ-019 SHALL on any other accept go IDLE->BUSY with the WIDTH+1-bit partial remainder loaded from dividend[2*WIDTH-1:WIDTH].
REQ-020 SHALL in BUSY run one restoring step per cycle, MSB first, for exactly WIDTH cycles: shift in the next dividend bit, subtract divisor if the result is >= divisor, record the quotient bit.
REQ-021 SHALL go BUSY->DONE after the WIDTH-th step, with err flags 0 and quotient*divisor+remainder == dividend and remainder < divisor.
REQ-022 SHALL drive out_valid=1 only in DONE: the cycle after accept for error cases, and WIDTH+1 cycles after accept otherwise.
REQ-023 SHALL hold quotient, remainder, err_dbz and err_ovf stable while out_valid=1 and out_ready=0.
REQ-024 SHALL go DONE->IDLE on out_valid=1 and out_ready=1; in_ready returns high the next cycle.
REQ-025 SHALL ignore in_valid in BUSY and DONE, with no accept and no state change.
REQ-026 SHALL ignore out_ready outside DONE.
REQ-027 SHALL drive quotient, remainder and error flags to 0 whenever out_valid=0.

Reset
REQ-028 SHALL on rst=1 at a clock edge enter IDLE, with in_ready=1 and out_valid=0; quotient, remainder, err_dbz and err_ovf are all 0.
REQ-029 SHALL let rst override every other input, including in BUSY or DONE, abandoning the operation in flight without producing a result.

Configuration
REQ-030 SHALL with macro DIVIDE_REMAINDER_EN defined compute and drive remainder per REQ-021.
REQ-031 SHALL with DIVIDE_REMAINDER_EN undefined keep the remainder port but tie it to 0, with no final remainder register; quotient, flags and timing are unchanged.

Verification (WIDTH=16, DIVIDE_REMAINDER_EN defined unless stated)
REQ-032 SHALL cover: dividend=0x00000064, divisor=7 -> quotient=0x000E, remainder=0x0002, out_valid first high 17 cycles after accept.
REQ-033 SHALL cover: dividend=0x12345678, divisor=0x1235 -> quotient=0xFFF6, remainder=0x0C8A, err flags 0; with the macro undefined, remainder=0x0000.
REQ-034 SHALL cover: divisor=0 with any dividend -> err_dbz=1, err_ovf=0, quotient=0xFFFF, remainder=0, out_valid 1 cycle after accept.
REQ-035 SHALL cover: dividend=0x00050000, divisor=5 -> err_ovf=1, quotient=0xFFFF, out_valid 1 cycle after accept.
REQ-036 SHALL cover: out_ready held 0 for 5 cycles in DONE while in_valid=1 -> outputs stable, in_ready=0, no accept; then out_ready=1 -> DONE->IDLE and in_ready=1 the next cycle.
REQ-037 SHALL cover: rst=1 on BUSY step 8 -> next cycle IDLE, in_ready=1, out_valid=0, all outputs 0, with no result ever emitted for that operation.
